fp_result_receiver: RTL and testbench

//  AXI4-Stream slave that terminates the m_axis_result_* port of the Kalman FP cores (add/sub/mul/div IPs).

---
 rtl/kalman_fp_pkg.sv | 16 +
 rtl/fp_result_receiver_if.sv | 33 +++
 rtl/fp_result_fifo.sv | 90 +++++++++
 rtl/fp_result_receiver.sv | 65 ++++++
 tb/tb_fp_result_receiver.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/kalman_fp_pkg.sv
// Shared FP32 definitions for the Kalman FP datapath.
//   FP32_W       single-precision word width
//   FP_EXP_MSB   exponent field MSB
//   FP_EXP_LSB   exponent field LSB
//   FP_EXP_ALL1  exponent pattern of NaN / Inf
//   fp32_t       one FP32 word
package kalman_fp_pkg;

  localparam int unsigned FP32_W      = 32;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;

  typedef logic [FP32_W-1:0] fp32_t;

endpackage

// File: rtl/fp_result_receiver_if.sv
// Bundle of the FP result receiver's data-facing signals.
//   s_tvalid/s_tready/s_tdata    AXI4-Stream result channel from the FP IP
//   out_valid/out_ready/out_data buffered results towards the Kalman datapath
//   level                        FIFO occupancy, 0..DEPTH
//   fp_err                       sticky NaN/Inf flag
// Modports:
//   slave   the receiver's view (accepts s_*, produces out_*)
//   master  the environment's view (IP plus datapath)
interface fp_result_receiver_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 3
);

  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  level;
  logic              fp_err;

  modport slave (
    input  s_tvalid, s_tdata, out_ready,
    output s_tready, out_valid, out_data, level, fp_err
  );

  modport master (
    output s_tvalid, s_tdata, out_ready,
    input  s_tready, out_valid, out_data, level, fp_err
  );

endinterface

// File: rtl/fp_result_fifo.sv
// Generic synchronous FIFO with registered handshake outputs and first-word
// fall-through from the register array.
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   push_valid  write request
//   push_ready  registered, high while not full (low during reset)
//   push_data   write word
//   pop_valid   registered, high while not empty
//   pop_ready   read acknowledge
//   pop_data    registered head word; holds its last value when empty
//   level       registered occupancy, 0..DEPTH
module fp_result_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  level
);

  localparam int unsigned     PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic              ready_q, valid_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push, pop;

  assign push = push_valid && ready_q;
  assign pop  = valid_q && pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
    // Next head: the word being written this edge if it lands on the new
    // read slot (empty FIFO, or level 1 with push+pop), else the array.
    if (level_d != '0) begin
      data_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= (level_d != Full);
      valid_q  <= (level_d != '0);
      data_q   <= data_d;
    end
  end

  assign push_ready = ready_q;
  assign pop_valid  = valid_q;
  assign pop_data   = data_q;
  assign level      = level_q;

endmodule

// File: rtl/fp_result_receiver.sv
// Terminates the m_axis_result_* port of a Kalman FP core (add/sub/mul/div),
// applying real backpressure, buffering FP32 results and handing them to the
// filter datapath on a valid/ready port.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    fp_result_receiver_if.slave: s_* from the IP, out_* to the
//          datapath, level occupancy, fp_err sticky NaN/Inf flag
// Build option: define FP_RESULT_CHECK_EN to flag accepted words whose
// exponent is all ones; otherwise fp_err is tied low.
module fp_result_receiver
  import kalman_fp_pkg::*;
#(
  parameter int unsigned DATA_W = FP32_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  fp_result_receiver_if.slave  bus
);

  fp_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (bus.s_tvalid),
    .push_ready (bus.s_tready),
    .push_data  (bus.s_tdata),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (bus.out_data),
    .level      (bus.level)
  );

`ifdef FP_RESULT_CHECK_EN
  logic fp_err_q;

  // Data is buffered unchanged; the flag only records that a NaN/Inf passed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fp_err_q <= 1'b0;
    end else if (bus.s_tvalid && bus.s_tready &&
                 (bus.s_tdata[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL1)) begin
      fp_err_q <= 1'b1;
    end
  end

  assign bus.fp_err = fp_err_q;
`else
  assign bus.fp_err = 1'b0;
`endif

  a_no_push_full: assert property (@(posedge clock) disable iff (reset)
    (bus.s_tvalid && bus.s_tready) |-> (bus.level != CNT_W'(DEPTH)));

  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
    (bus.out_valid && bus.out_ready) |-> (bus.level != '0));

  a_data_stable: assert property (@(posedge clock) disable iff (reset)
    (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_data));

endmodule

// File: tb/tb_fp_result_receiver.sv
// Directed bench for fp_result_receiver: reset state, single beat, fill to
// full with a held beat, pop-while-full, push+pop streaming across pointer
// wrap, reset mid-operation and the NaN/Inf flag.
module tb_fp_result_receiver;

  logic clock;
  logic reset;
  int   chk_cnt;
  int   pass_cnt;

  fp_result_receiver_if #(.DATA_W(32), .CNT_W(3)) bus ();

  fp_result_receiver #(
    .DATA_W (32),
    .DEPTH  (4),
    .CNT_W  (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Advance one rising edge, then move #1 past it for sampling/driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] fill [5];
  logic [31:0] exp_q [$];
  logic [31:0] d;
  logic        exp_err;

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    fill[0] = 32'h4000_0000;
    fill[1] = 32'h4010_0000;
    fill[2] = 32'h4020_0000;
    fill[3] = 32'h4040_0000;
    fill[4] = 32'h4080_0000;
`ifdef FP_RESULT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    reset         = 1'b1;
    bus.s_tvalid  = 1'b0;
    bus.s_tdata   = '0;
    bus.out_ready = 1'b0;
    step();
    check("rst_tready", bus.s_tready, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_level", bus.level, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_err", bus.fp_err, 0);
    step();
    reset = 1'b0;
    step();
    check("rel_tready", bus.s_tready, 1);

    // 1: single beat with consumer ready
    bus.out_ready = 1'b1;
    bus.s_tvalid  = 1'b1;
    bus.s_tdata   = 32'h3F80_0000;
    step();
    bus.s_tvalid = 1'b0;
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 32'h3F80_0000);
    check("t1_level1", bus.level, 1);
    step();
    check("t1_level0", bus.level, 0);
    check("t1_empty", bus.out_valid, 0);

    // 2: fill with consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = fill[i];
      step();
      check($sformatf("t2_level%0d", i), bus.level, 32'(i + 1));
      check($sformatf("t2_tready%0d", i), bus.s_tready, (i < 3) ? 1 : 0);
    end
    bus.s_tdata = fill[4];
    step();
    step();
    check("t2_held_level", bus.level, 4);
    check("t2_held_tready", bus.s_tready, 0);
    check("t2_head", bus.out_data, fill[0]);

    // 3: one pop while full, held beat goes in on the next edge
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t3_level3", bus.level, 3);
    check("t3_tready", bus.s_tready, 1);
    check("t3_head", bus.out_data, fill[1]);
    step();
    bus.s_tvalid = 1'b0;
    check("t3_level4", bus.level, 4);
    check("t3_full", bus.s_tready, 0);
    check("t3_head_kept", bus.out_data, fill[1]);

    // drain to level 2
    bus.out_ready = 1'b1;
    step();
    check("dr_data", bus.out_data, fill[2]);
    step();
    check("dr_level", bus.level, 2);

    // 4: simultaneous push+pop across wrap
    exp_q.push_back(fill[3]);
    exp_q.push_back(fill[4]);
    bus.s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 32'h4100_0000 + (32'(i) << 16);
      bus.s_tdata = d;
      check($sformatf("t4_data%0d", i), bus.out_data, exp_q[0]);
      exp_q.push_back(d);
      void'(exp_q.pop_front());
      step();
      check($sformatf("t4_level%0d", i), bus.level, 2);
    end
    bus.out_ready = 1'b0;
    bus.s_tdata   = 32'h4200_0000;
    step();
    bus.s_tvalid = 1'b0;
    check("t4_order_tail", bus.out_data, exp_q[0]);
    check("t4_level3", bus.level, 3);

    // 5: asynchronous reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    check("t5_valid", bus.out_valid, 0);
    check("t5_level", bus.level, 0);
    check("t5_tready", bus.s_tready, 0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("t5_rel_tready", bus.s_tready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_stale%0d", i), bus.out_valid, 0);
    end

    // 6: NaN flag
    check("t6_err_before", bus.fp_err, 0);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 32'h7FC0_0000;
    step();
    bus.s_tvalid = 1'b0;
    check("t6_data", bus.out_data, 32'h7FC0_0000);
    step();
    check("t6_err", bus.fp_err, exp_err);
    check("t6_drained", bus.level, 0);
    step();
    step();
    check("t6_err_sticky", bus.fp_err, exp_err);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
